// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with a 2-entry prefetch FIFO and IF/ID
// register.
//
// Parameters
//   XLEN      width of addresses and instruction words
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, rstn            clock (rising edge) and asynchronous active-low reset
//   stall_pc             1 = fetch may advance; 0 = PC holds, no new fetch
//   hold_ifid            1 = IF/ID outputs hold
//   flush, redirect_pc   redirect request and its target (low 2 bits ignored)
//   imem_req, imem_addr  fetch request / word-aligned address (registered)
//   imem_ack, imem_rdata acceptance with same-cycle instruction data
//   id_valid, id_pc,     IF/ID register contents
//   id_instr
//
// At most one imem transaction is ever outstanding. A flush that lands while a
// request is waiting cannot cancel it (req/addr must stay stable), so the FSM
// parks in DROP until the stale ack returns and only then fetches the target.
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall_pc,
    input  logic            hold_ifid,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;      // in REQ: address in flight; else next to issue
    logic [XLEN-1:0] fq_pc  [2];
    logic [XLEN-1:0] fq_ins [2];
    logic            rd_ptr, wr_ptr;
    logic [1:0]      cnt;

    logic            ack, keep, load_id, pop, bypass, push, busy_after, issue;
    logic [1:0]      cnt_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic            unused_lsb;

    assign unused_lsb = ^redirect_pc[1:0];

    // An ack only counts while a request is actually presented.
    assign ack     = imem_req & imem_ack;
    // Data worth keeping: answer to a live (non-dropped) request, no redirect now.
    assign keep    = (state == REQ) & ack & ~flush;
    assign load_id = ~hold_ifid & ~flush;
    assign pop     = load_id & (cnt != 2'd0);
    // Empty FIFO: ack data goes straight into IF/ID instead of through the FIFO.
    assign bypass  = load_id & (cnt == 2'd0) & keep;
    assign push    = keep & ~bypass;

    always_comb begin
        cnt_nxt = cnt;
        if (flush)
            cnt_nxt = 2'd0;
        else begin
            case ({push, pop})
                2'b10:   cnt_nxt = cnt + 2'd1;
                2'b01:   cnt_nxt = cnt - 2'd1;
                default: cnt_nxt = cnt;
            endcase
        end
    end

    assign pc_nxt = flush ? {redirect_pc[XLEN-1:2], 2'b00}
                  : keep  ? fetch_pc + XLEN'(4)
                  :         fetch_pc;

    // A transaction still in flight after this edge blocks a new issue.
    assign busy_after = (state != IDLE) & ~ack;
    // Occupancy is judged after this cycle's push/pop so a full stream of
    // zero-wait acks with IF/ID draining keeps one fetch per cycle.
    assign issue = stall_pc & (state != DROP) & ~busy_after & (cnt_nxt != 2'd2);

    // Fetch FSM; imem_req/imem_addr are registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
        end else begin
            fetch_pc <= pc_nxt;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_nxt;
                    end
                end
                REQ: begin
                    if (ack) begin
                        if (issue)
                            imem_addr <= pc_nxt;
                        else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end else if (flush)
                        state <= DROP;   // keep req/addr stable, wait for stale ack
                end
                DROP: begin
                    if (ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // FIFO control.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            cnt <= cnt_nxt;
            if (flush) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
            end
        end
    end

    // FIFO storage needs no reset; cnt qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fq_pc[wr_ptr]  <= imem_addr;
            fq_ins[wr_ptr] <= imem_rdata;
        end
    end

    // IF/ID register. On flush only the valid bit is cleared.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_instr <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (!hold_ifid) begin
            if (cnt != 2'd0) begin
                id_valid <= 1'b1;
                id_pc    <= fq_pc[rd_ptr];
                id_instr <= fq_ins[rd_ptr];
            end else if (keep) begin
                id_valid <= 1'b1;
                id_pc    <= imem_addr;
                id_instr <= imem_rdata;
            end else begin
                id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- directed scenarios followed by a randomized run, all checked
// against a queue-based reference of the fetch stream and IF/ID behaviour.
// A second instance with RESET_PC = 0xFFFF_FFFC shares the inputs to cover
// address wrap-around.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall_pc, hold_ifid, flush, imem_ack;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr, id_pc, id_instr;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_pc, w_instr;

    if_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rstn(rstn), .stall_pc(stall_pc), .hold_ifid(hold_ifid),
        .flush(flush), .redirect_pc(redirect_pc), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr)
    );

    if_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rstn(rstn), .stall_pc(stall_pc), .hold_ifid(hold_ifid),
        .flush(flush), .redirect_pc(redirect_pc), .imem_req(w_req),
        .imem_addr(w_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(w_valid), .id_pc(w_pc), .id_instr(w_instr)
    );

    always #5 clk = ~clk;

    int n_chk, n_fail, kept_cnt;

    // Reference state: expected fetch stream, model FIFO, expected IF/ID.
    ent_t        mq[$];
    logic [31:0] exp_pc;
    logic        stale;          // outstanding request was overtaken by a flush
    logic        ev;
    logic [31:0] epc, ein;
    logic        prev_req, prev_ack, prev_stall;
    logic [31:0] prev_addr;
    logic        redir_pend;
    logic [31:0] redir_tgt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_pc     = 32'h0;
        stale      = 1'b0;
        ev         = 1'b0;
        epc        = 32'h0;
        ein        = 32'h0;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_stall = 1'b0;
        prev_addr  = 32'h0;
        redir_pend = 1'b0;
        redir_tgt  = 32'h0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"},   64'(imem_req), 64'(0));
        chk({tag, "_valid"}, 64'(id_valid), 64'(0));
        chk({tag, "_pc"},    64'(id_pc),    64'(0));
        chk({tag, "_instr"}, 64'(id_instr), 64'(0));
        chk({tag, "_wreq"},  64'(w_req),    64'(0));
    endtask

    // One clock cycle: drive inputs at negedge, check the current cycle's
    // protocol, advance the reference, then check IF/ID after the edge.
    task automatic step(input logic s, input logic h, input logic f,
                        input logic [31:0] rpc, input logic a, input logic [31:0] salt);
        logic        ackv, kept, stale_old, byp;
        logic [31:0] rd;
        ent_t        e;
        @(negedge clk);
        ackv = a & imem_req;
        rd   = imem_addr ^ 32'hA5A5_0000 ^ salt;
        stall_pc = s; hold_ifid = h; flush = f; redirect_pc = rpc;
        imem_ack = ackv; imem_rdata = rd;

        if (redir_pend)
            chk("redirect_latency", 64'({imem_req, imem_addr}), 64'({1'b1, redir_tgt}));
        redir_pend = 1'b0;
        if (prev_req && !prev_ack)
            chk("req_stable", 64'({imem_req, imem_addr}), 64'({1'b1, prev_addr}));
        if (imem_req && (!prev_req || prev_ack))
            chk("issue_gate", 64'(prev_stall), 64'(1));
        if (imem_req)
            chk("addr_align", 64'(imem_addr[1:0]), 64'(0));
        chk("occupancy", 64'((mq.size() + int'(imem_req)) <= 2), 64'(1));

        stale_old = stale;
        kept = ackv && !stale_old && !f;
        byp  = 1'b0;
        if (kept) begin
            chk("fetch_addr", 64'(imem_addr), 64'(exp_pc));
            kept_cnt++;
        end

        if (f) begin
            mq.delete();
            ev     = 1'b0;
            stale  = imem_req && !ackv;
            exp_pc = {rpc[31:2], 2'b00};
            if (s && (!imem_req || (ackv && !stale_old))) begin
                redir_pend = 1'b1;
                redir_tgt  = exp_pc;
            end
        end else begin
            if (ackv && stale_old) stale = 1'b0;
            if (!h) begin
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    ev = 1'b1; epc = e.pc; ein = e.ins;
                end else if (kept) begin
                    ev = 1'b1; epc = imem_addr; ein = rd; byp = 1'b1;
                end else
                    ev = 1'b0;
            end
            if (kept && !byp) begin
                e.pc = imem_addr; e.ins = rd;
                mq.push_back(e);
            end
            if (kept) exp_pc = exp_pc + 32'd4;
        end
        chk("fifo_bound", 64'(mq.size() <= 2), 64'(1));

        prev_req = imem_req; prev_ack = ackv; prev_addr = imem_addr; prev_stall = s;

        @(posedge clk);
        #1;
        chk("id_valid", 64'(id_valid), 64'(ev));
        if (ev) begin
            chk("id_pc",    64'(id_pc),    64'(epc));
            chk("id_instr", 64'(id_instr), 64'(ein));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; kept_cnt = 0;
        rstn = 1'b0; stall_pc = 1'b1; hold_ifid = 1'b0; flush = 1'b0;
        redirect_pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        model_reset();

        // Power-on reset; acks during reset must be ignored.
        repeat (3) @(posedge clk);
        imem_ack = 1'b1;
        @(posedge clk); #1;
        check_reset("por");
        #1 rstn = 1'b1; imem_ack = 1'b0;

        // Zero-wait stream, first fetch right after release, wrap instance.
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 0, 32'h0, 1, 32'h0);
            if (k == 1) begin
                chk("first_req",  64'({imem_req, imem_addr}), 64'({1'b1, 32'h0}));
                chk("wrap_first", 64'(w_addr), 64'(32'hFFFF_FFFC));
            end
            if (k == 2) chk("wrap_second", 64'(w_addr), 64'(32'h0));
            if (k >= 2) begin
                chk("stream_valid", 64'(id_valid), 64'(1));
                chk("stream_pc",    64'(id_pc),    64'((k - 2) * 4));
                chk("stream_instr", 64'(id_instr), 64'(((k - 2) * 4) ^ 32'hA5A5_0000));
            end
        end

        // Load-use stall while id_pc = 0x8.
        step(0, 1, 0, 32'h0, 1, 32'h0);
        chk("loaduse_hold", 64'({id_valid, id_pc}), 64'({1'b1, 32'h8}));
        step(1, 0, 0, 32'h0, 1, 32'h0);
        chk("loaduse_next", 64'(id_pc), 64'(32'hC));
        step(1, 0, 0, 32'h0, 1, 32'h0);
        chk("loaduse_next2", 64'(id_pc), 64'(32'h10));

        // Flush while a request waits: get a request at 0x10, then delay its ack.
        step(1, 0, 1, 32'h10, 1, 32'h0);
        chk("setup_0x10", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h10}));
        step(1, 0, 0, 32'h0, 0, 32'h0);
        step(1, 0, 1, 32'h100, 0, 32'h0);
        chk("drop_addr_held", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h10}));
        chk("drop_invalid",   64'(id_valid), 64'(0));
        step(1, 0, 0, 32'h0, 0, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'h1234_5678);
        chk("drop_discard", 64'({id_valid, imem_req}), 64'(0));
        step(1, 0, 0, 32'h0, 1, 32'h0);
        chk("drop_redirect", 64'({imem_req, imem_addr, id_valid}), 64'({1'b1, 32'h100, 1'b0}));
        step(1, 0, 0, 32'h0, 1, 32'h0);
        chk("drop_target_data", 64'({id_valid, id_pc}), 64'({1'b1, 32'h100}));

        // Flush coincident with ack, unaligned target.
        step(1, 0, 1, 32'h20, 1, 32'h0);
        chk("setup_0x20", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h20}));
        step(1, 0, 1, 32'h203, 1, 32'h0);
        chk("coinc_redirect", 64'({imem_req, imem_addr, id_valid}), 64'({1'b1, 32'h200, 1'b0}));
        step(1, 0, 0, 32'h0, 1, 32'h0);
        chk("coinc_target_data", 64'({id_valid, id_pc}), 64'({1'b1, 32'h200}));

        // Reset mid-operation with one FIFO entry and a request in flight.
        step(1, 1, 0, 32'h0, 1, 32'h0);
        step(1, 1, 0, 32'h0, 0, 32'h0);
        chk("pre_reset_busy", 64'({imem_req, imem_addr, id_pc}), 64'({1'b1, 32'h208, 32'h200}));
        #1 rstn = 1'b0;
        #1 check_reset("async");
        imem_ack = 1'b1;
        @(posedge clk); #1;
        check_reset("held");
        #1 rstn = 1'b1; imem_ack = 1'b0;
        model_reset();
        step(1, 0, 0, 32'h0, 1, 32'h0);
        chk("restart_req", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h0}));

        // Randomized run against the reference.
        kept_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            logic        s, h, f, a;
            logic [31:0] r;
            s = ($urandom % 5) != 0;
            h = ($urandom % 4) == 0;
            f = ($urandom % 14) == 0;
            a = ($urandom % 3) != 0;
            r = (($urandom % 4) == 0) ? (32'hFFFF_FFF4 | ($urandom & 32'h3)) : $urandom;
            step(s, h, f, r, a, $urandom);
        end
        chk("progress", 64'(kept_cnt > 100), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
